// File: rtl/fb_pkg.sv
// Shared types and sizes for the framebuffer arbiter and its starvation guard.
package fb_pkg;
  localparam int FB_ADDR_W     = 11;
  localparam int FB_DATA_W     = 16;
  localparam int FB_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    WR   = 2'd3
  } fb_arb_state_t;
endpackage

// File: rtl/framebuffer_arbiter_starve.sv
// Write-deferral counter: counts read grants taken while a write waits and
// asks for a forced write once WR_STARVE_LIMIT of them have gone by.
module framebuffer_arbiter_starve #(
  parameter int WR_STARVE_LIMIT = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic rd_grant_i,
  input  logic wr_grant_i,
  input  logic wr_req_i,
  output logic force_wr_o
);
  localparam logic [3:0] LIMIT = 4'(WR_STARVE_LIMIT);

  logic [3:0] defer_cnt_q, defer_cnt_d;

  // Saturates at LIMIT so the force stays asserted until the write is granted.
  always_comb begin
    defer_cnt_d = defer_cnt_q;
    if (wr_grant_i) begin
      defer_cnt_d = 4'd0;
    end else if (rd_grant_i && wr_req_i && (defer_cnt_q != LIMIT)) begin
      defer_cnt_d = defer_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      defer_cnt_q <= 4'd0;
    end else begin
      defer_cnt_q <= defer_cnt_d;
    end
  end

  assign force_wr_o = (defer_cnt_q == LIMIT);
endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares the single-port framebuffer RAM between display reads and host writes.
// Define FB_ARB_STARVE_GUARD_EN to bound how long reads may defer a write.
module framebuffer_arbiter
  import fb_pkg::*;
#(
  parameter int WR_STARVE_LIMIT = 4
) (
  input  logic                 reset,
  input  logic                 clk_in,
  input  logic                 disp_req,
  input  logic [FB_ADDR_W-1:0] disp_addr,
  output logic [FB_DATA_W-1:0] disp_data,
  output logic                 disp_valid,
  output logic                 disp_overrun,
  input  logic                 wr_req,
  input  logic [FB_ADDR_W-1:0] wr_addr,
  input  logic [FB_DATA_W-1:0] wr_data,
  output logic                 wr_ack,
  output logic [FB_ADDR_W-1:0] ram_addr,
  output logic [FB_DATA_W-1:0] ram_data_out,
  input  logic [FB_DATA_W-1:0] ram_data_in,
  output logic                 ram_write_enable,
  output logic                 ram_clk_enable,
  output logic                 busy,
  output fb_arb_state_t        dbg_state_o
);
  fb_arb_state_t        state_q;
  logic                 disp_pending_q;
  logic [FB_ADDR_W-1:0] disp_addr_q;
  logic [FB_DATA_W-1:0] disp_data_q;
  logic                 disp_valid_q;
  logic                 disp_overrun_q;
  logic                 wr_ack_q;
  logic [FB_ADDR_W-1:0] ram_addr_q;
  logic [FB_DATA_W-1:0] ram_data_out_q;
  logic                 ram_we_q;
  logic                 ram_ce_q;

  logic                 is_idle;
  logic                 rd_want;
  logic                 force_wr;
  logic                 wr_grant;
  logic                 rd_grant;
  logic [FB_ADDR_W-1:0] rd_addr;

  assign is_idle = (state_q == IDLE);
  assign rd_want = disp_req || disp_pending_q;
  // The wr_ack term keeps a requester still holding wr_req from a second grant.
  assign wr_grant = is_idle && wr_req && (force_wr || (!rd_want && !wr_ack_q));
  assign rd_grant = is_idle && rd_want && !wr_grant;
  assign rd_addr  = disp_pending_q ? disp_addr_q : disp_addr;

`ifdef FB_ARB_STARVE_GUARD_EN
  framebuffer_arbiter_starve #(
    .WR_STARVE_LIMIT(WR_STARVE_LIMIT)
  ) u_starve (
    .clk_in    (clk_in),
    .reset     (reset),
    .rd_grant_i(rd_grant),
    .wr_grant_i(wr_grant),
    .wr_req_i  (wr_req),
    .force_wr_o(force_wr)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (WR_STARVE_LIMIT > 0);
  assign force_wr = 1'b0;
`endif

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      disp_pending_q <= 1'b0;
      disp_addr_q    <= '0;
      disp_data_q    <= '0;
      disp_valid_q   <= 1'b0;
      disp_overrun_q <= 1'b0;
      wr_ack_q       <= 1'b0;
      ram_addr_q     <= '0;
      ram_data_out_q <= '0;
      ram_we_q       <= 1'b0;
      ram_ce_q       <= 1'b0;
    end else begin
      disp_valid_q <= 1'b0;
      wr_ack_q     <= 1'b0;

      // A request is latched unless it is granted live; a second one is lost.
      if (disp_req && disp_pending_q) begin
        disp_overrun_q <= 1'b1;
      end
      if (disp_req && !disp_pending_q && !rd_grant) begin
        disp_pending_q <= 1'b1;
        disp_addr_q    <= disp_addr;
      end else if (rd_grant) begin
        disp_pending_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (wr_grant) begin
            ram_addr_q     <= wr_addr;
            ram_data_out_q <= wr_data;
            ram_we_q       <= 1'b1;
            ram_ce_q       <= 1'b1;
            state_q        <= WR;
          end else if (rd_grant) begin
            ram_addr_q <= rd_addr;
            ram_we_q   <= 1'b0;
            ram_ce_q   <= 1'b1;
            state_q    <= RD1;
          end
        end
        RD1: state_q <= RD2;
        RD2: begin
          disp_data_q  <= ram_data_in;
          disp_valid_q <= 1'b1;
          ram_ce_q     <= 1'b0;
          state_q      <= IDLE;
        end
        WR: begin
          ram_we_q <= 1'b0;
          ram_ce_q <= 1'b0;
          wr_ack_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp_data        = disp_data_q;
  assign disp_valid       = disp_valid_q;
  assign disp_overrun     = disp_overrun_q;
  assign wr_ack           = wr_ack_q;
  assign ram_addr         = ram_addr_q;
  assign ram_data_out     = ram_data_out_q;
  assign ram_write_enable = ram_we_q;
  assign ram_clk_enable   = ram_ce_q;
  assign busy             = !is_idle;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: behavioural RAM with two-cycle reads, a
// reference memory image, directed cases and randomized read/write traffic.
module tb_framebuffer_arbiter;
  import fb_pkg::*;

  logic          reset;
  logic          clk_in;
  logic          disp_req;
  logic [10:0]   disp_addr;
  logic [15:0]   disp_data;
  logic          disp_valid;
  logic          disp_overrun;
  logic          wr_req;
  logic [10:0]   wr_addr;
  logic [15:0]   wr_data;
  logic          wr_ack;
  logic [10:0]   ram_addr;
  logic [15:0]   ram_data_out;
  logic [15:0]   ram_data_in;
  logic          ram_write_enable;
  logic          ram_clk_enable;
  logic          busy;
  fb_arb_state_t dbg_state;

  framebuffer_arbiter #(.WR_STARVE_LIMIT(4)) dut (
    .reset           (reset),
    .clk_in          (clk_in),
    .disp_req        (disp_req),
    .disp_addr       (disp_addr),
    .disp_data       (disp_data),
    .disp_valid      (disp_valid),
    .disp_overrun    (disp_overrun),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .ram_addr        (ram_addr),
    .ram_data_out    (ram_data_out),
    .ram_data_in     (ram_data_in),
    .ram_write_enable(ram_write_enable),
    .ram_clk_enable  (ram_clk_enable),
    .busy            (busy),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // ---------------- RAM model: registered read, so data lands two edges after grant
  logic [15:0] mem [0:2047];
  logic [15:0] ref_mem [0:2047];
  logic [15:0] rd_q;
  int          ram_wr_count;
  initial ram_wr_count = 0;

  always @(posedge clk_in) begin
    if (ram_clk_enable) begin
      if (ram_write_enable) begin
        mem[ram_addr] <= ram_data_out;
        ram_wr_count  <= ram_wr_count + 1;
      end
      rd_q <= mem[ram_addr];
    end
  end
  assign ram_data_in = rd_q;

  int n_valid;
  int n_ack;
  initial begin
    n_valid = 0;
    n_ack   = 0;
  end
  always @(negedge clk_in) begin
    if (disp_valid) n_valid <= n_valid + 1;
    if (wr_ack)     n_ack   <= n_ack + 1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_bad;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    disp_req  = 1'b0;
    wr_req    = 1'b0;
    disp_addr = '0;
    wr_addr   = '0;
    wr_data   = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Read from an idle arbiter: data must appear exactly two edges after sampling.
  task automatic read_idle(input logic [10:0] a, input string tag);
    logic [15:0] exp;
    exp = ref_mem[a];
    disp_req  = 1'b1;
    disp_addr = a;
    tick();
    disp_req  = 1'b0;
    disp_addr = 11'($urandom_range(0, 2047));
    check_eq($sformatf("%s_addr", tag), 32'(ram_addr), 32'(a));
    check_eq($sformatf("%s_we0", tag), 32'(ram_write_enable), 32'd0);
    tick();
    check_eq($sformatf("%s_early", tag), 32'(disp_valid), 32'd0);
    check_eq($sformatf("%s_we1", tag), 32'(ram_write_enable), 32'd0);
    tick();
    check_eq($sformatf("%s_valid", tag), 32'(disp_valid), 32'd1);
    check_eq($sformatf("%s_data", tag), 32'(disp_data), 32'(exp));
  endtask

  // Write held through the ack cycle; exactly one RAM write must result.
  task automatic write_op(input logic [10:0] a, input logic [15:0] d, input string tag);
    int  base;
    int  cyc;
    bit  got;
    base    = ram_wr_count;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    got     = 1'b0;
    cyc     = 0;
    while (!got && cyc < 20) begin
      tick();
      cyc++;
      if (wr_ack) got = 1'b1;
    end
    check_eq($sformatf("%s_ack", tag), 32'(got), 32'd1);
    check_eq($sformatf("%s_lat", tag), 32'(cyc), 32'd2);
    tick();
    check_eq($sformatf("%s_regrant", tag), 32'(busy), 32'd0);
    wr_req = 1'b0;
    tick();
    check_eq($sformatf("%s_nwr", tag), 32'(ram_wr_count - base), 32'd1);
    check_eq($sformatf("%s_mem", tag), 32'(mem[a]), 32'(d));
    ref_mem[a] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          reads_before;
    int          acks_before;
    int          ack_seen;
    int          base_v;
    int          base_a;
    logic [10:0] a;
    logic [10:0] b;
    logic [15:0] d;

    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 2048; i++) begin
      d          = 16'($urandom_range(0, 65535));
      mem[i]     = d;
      ref_mem[i] = d;
    end
    mem[11'h123]     = 16'hBEEF;
    ref_mem[11'h123] = 16'hBEEF;

    // Reset state
    do_reset();
    check_eq("rst_disp_data", 32'(disp_data), 32'd0);
    check_eq("rst_disp_valid", 32'(disp_valid), 32'd0);
    check_eq("rst_overrun", 32'(disp_overrun), 32'd0);
    check_eq("rst_wr_ack", 32'(wr_ack), 32'd0);
    check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_eq("rst_ram_dout", 32'(ram_data_out), 32'd0);
    check_eq("rst_ram_we", 32'(ram_write_enable), 32'd0);
    check_eq("rst_ram_ce", 32'(ram_clk_enable), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);

    // Single read and single write
    read_idle(11'h123, "rd_beef");
    write_op(11'h7FF, 16'h1234, "wr_7ff");
    read_idle(11'h7FF, "rd_7ff");

    // Collision: read first, write on the next idle edge
    a = 11'h055;
    exp_q.push_back(32'(ref_mem[a]));
    disp_req  = 1'b1;
    disp_addr = a;
    wr_req    = 1'b1;
    wr_addr   = a;
    wr_data   = 16'hA5A5;
    tick();
    disp_req = 1'b0;
    check_eq("col_rd_first", 32'(ram_write_enable), 32'd0);
    tick();
    tick();
    check_eq("col_valid", 32'(disp_valid), 32'd1);
    check_eq("col_old_data", 32'(disp_data), exp_q.pop_front());
    tick();
    check_eq("col_wr_we", 32'(ram_write_enable), 32'd1);
    tick();
    check_eq("col_wr_ack", 32'(wr_ack), 32'd1);
    tick();
    wr_req = 1'b0;
    ref_mem[a] = 16'hA5A5;
    check_eq("col_overrun", 32'(disp_overrun), 32'd0);
    read_idle(a, "col_rdback");

    // Reset in the middle of a write: enable must drop without a clock
    a = 11'h321;
    d = ~ref_mem[a];
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    acks_before = n_ack;
    tick();
    check_eq("midwr_we_hi", 32'(ram_write_enable), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midwr_we_async", 32'(ram_write_enable), 32'd0);
    check_eq("midwr_busy", 32'(busy), 32'd0);
    tick();
    wr_req = 1'b0;
    reset  = 1'b0;
    tick();
    tick();
    check_eq("midwr_no_ack", 32'(n_ack - acks_before), 32'd0);
    check_eq("midwr_mem", 32'(mem[a]), 32'(ref_mem[a]));

    // Overrun: three extra pulses behind an in-flight read
    a = 11'h010;
    b = 11'h020;
    base_v = n_valid;
    disp_req  = 1'b1;
    disp_addr = a;
    tick();
    disp_addr = b;
    tick();
    check_eq("ovr_not_yet", 32'(disp_overrun), 32'd0);
    disp_addr = 11'h030;
    tick();
    check_eq("ovr_a_data", 32'(disp_data), 32'(ref_mem[a]));
    check_eq("ovr_flag", 32'(disp_overrun), 32'd1);
    disp_addr = 11'h040;
    tick();
    disp_req = 1'b0;
    tick();
    tick();
    check_eq("ovr_b_valid", 32'(disp_valid), 32'd1);
    check_eq("ovr_b_data", 32'(disp_data), 32'(ref_mem[b]));
    for (int i = 0; i < 8; i++) tick();
    check_eq("ovr_reads", 32'(n_valid - base_v), 32'd2);
    check_eq("ovr_sticky", 32'(disp_overrun), 32'd1);

    // Randomized sequential traffic against the reference memory image
    do_reset();
    for (int i = 0; i < 40; i++) begin
      a = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 1) == 0) begin
        read_idle(a, $sformatf("rnd_rd%0d", i));
      end else begin
        write_op(a, 16'($urandom_range(0, 65535)), $sformatf("rnd_wr%0d", i));
      end
    end
    check_eq("rnd_overrun", 32'(disp_overrun), 32'd0);

    // Starvation: display pulses every cycle while a write is held
    do_reset();
    base_v       = n_valid;
    reads_before = -1;
    ack_seen     = 0;
    wr_req  = 1'b1;
    wr_addr = 11'h100;
    wr_data = 16'h5A5A;
    for (int i = 0; i < 100; i++) begin
      disp_req  = 1'b1;
      disp_addr = 11'($urandom_range(0, 2047));
      tick();
      if (wr_ack && ack_seen == 0) begin
        reads_before = n_valid - base_v;
        if (disp_valid) reads_before++;
        ack_seen = 1;
        wr_req   = 1'b0;
      end
    end
    disp_req = 1'b0;
    wr_req   = 1'b0;
`ifdef FB_ARB_STARVE_GUARD_EN
    check_eq("starve_ack", 32'(ack_seen), 32'd1);
    check_eq("starve_reads", 32'(reads_before), 32'd4);
`else
    check_eq("starve_no_ack", 32'(ack_seen), 32'd0);
    check_eq("starve_reads_flow", 32'((n_valid - base_v) > 20), 32'd1);
`endif
    for (int i = 0; i < 10; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
